// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: cache-to-memory handshake between one cache controller and the arbiter
interface mem_arbiter_if;
  logic        req;
  logic        re;
  logic        we;
  logic        gnt;
  logic        ready;
  logic [31:0] addr;
  logic [31:0] dataOut;
  logic [31:0] dataIn;
  modport master (output req, addr, dataOut, re, we, input gnt, dataIn, ready);
  modport slave (input req, addr, dataOut, re, we, output gnt, dataIn, ready);
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: burst-granular two-master memory port arbiter with rotating priority and beat-budget preemption
module mem_arbiter #(
  parameter int MAX_BURST = 256,
  parameter int CNT_WIDTH = 9
) (
  input  logic         clk,
  input  logic         res,
  mem_arbiter_if.slave i_bus,
  mem_arbiter_if.slave d_bus,
  output logic [31:0]  mem_addr,
  output logic [31:0]  mem_dataOut,
  output logic         mem_re,
  output logic         mem_we,
  input  logic [31:0]  mem_dataIn,
  input  logic         mem_ready
);
  typedef enum logic [1:0] {S_IDLE, S_GNT_I, S_GNT_D} state_t;
  localparam logic [CNT_WIDTH-1:0] MAX = CNT_WIDTH'(MAX_BURST);
  state_t               state_q, state_d;
  logic                 last_q, last_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 sel_i, sel_d, x_req, o_req, strobe, beat;
  // Both requesting: the master that did not hold the bus last wins
  function automatic state_t arb(input logic ri, input logic rd, input logic last);
    return (ri & rd) ? (last ? S_GNT_I : S_GNT_D) : ri ? S_GNT_I : rd ? S_GNT_D : S_IDLE;
  endfunction
  // Route the owning master onto the memory port; write beats a simultaneous read
  always_comb begin
    sel_i         = state_q == S_GNT_I;
    sel_d         = state_q == S_GNT_D;
    x_req         = sel_i ? i_bus.req : sel_d ? d_bus.req : 1'b0;
    o_req         = sel_i ? d_bus.req : i_bus.req;
    mem_we        = sel_i ? i_bus.we : sel_d ? d_bus.we : 1'b0;
    mem_re        = (sel_i ? i_bus.re : sel_d ? d_bus.re : 1'b0) & ~mem_we;
    mem_addr      = sel_i ? i_bus.addr : sel_d ? d_bus.addr : '0;
    mem_dataOut   = sel_i ? i_bus.dataOut : sel_d ? d_bus.dataOut : '0;
    strobe        = mem_re | mem_we;
    beat          = strobe & mem_ready;
    i_bus.gnt     = sel_i;
    d_bus.gnt     = sel_d;
    i_bus.ready   = sel_i & beat;
    d_bus.ready   = sel_d & beat;
    i_bus.dataIn  = sel_i ? mem_dataIn : '0;
    d_bus.dataIn  = sel_d ? mem_dataIn : '0;
  end
  // Hold through an open beat, preempt on budget exhaustion, else re-arbitrate once the owner lets go
  always_comb begin
    state_d = (strobe & ~mem_ready) ? state_q :
              (beat && cnt_q + 1'b1 == MAX && o_req) ? (sel_i ? S_GNT_D : S_GNT_I) :
              (~x_req & ~strobe) ? arb(i_bus.req, d_bus.req, last_q) : state_q;
    last_d  = state_d == S_GNT_I ? 1'b0 : state_d == S_GNT_D ? 1'b1 : last_q;
    cnt_d   = state_d != state_q ? '0 : (beat && cnt_q != MAX) ? cnt_q + 1'b1 : cnt_q;
  end
  // Arbitration state; lastGnt resets to D so I wins the first tie
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end
  a_hold_i: assert property (@(posedge clk) disable iff (!res)
    (sel_i && (i_bus.re | i_bus.we) && !mem_ready) |=> $stable({i_bus.re, i_bus.we, i_bus.addr, i_bus.dataOut}));
  a_hold_d: assert property (@(posedge clk) disable iff (!res)
    (sel_d && (d_bus.re | d_bus.we) && !mem_ready) |=> $stable({d_bus.re, d_bus.we, d_bus.addr, d_bus.dataOut}));
endmodule
